// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: one command in flight,
// IDLE -> ISSUE -> WAIT -> ACK. Define SRAM_ARB_RR_EN for round-robin contention.
module sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int RDATA_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_rd_en,
    input  logic               req0_wr_en,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic [31:0]        req0_wdata,
    input  logic               req1_rd_en,
    input  logic               req1_wr_en,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic [31:0]        req1_wdata,
    output logic               ack0,
    output logic               ack1,
    output logic [RDATA_W-1:0] rdata,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic               sram_ready,
    input  logic [RDATA_W-1:0] sram_rdata,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t             state_reg, state_next;
    logic               grant_reg;
    logic               op_wr_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic [RDATA_W-1:0] rdata_reg;
    logic               winner;

    logic [1:0] rd_vec, wr_vec, req_vec, ack_vec;

    assign rd_vec = {req1_rd_en, req0_rd_en};
    assign wr_vec = {req1_wr_en, req0_wr_en};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_vec[gi] = rd_vec[gi] | wr_vec[gi];
            assign ack_vec[gi] = (state_reg == ACK) && (grant_reg == 1'(gi));
        end
    endgenerate

`ifdef SRAM_ARB_RR_EN
    logic last_grant_reg;
`endif

    always_comb begin
        winner = 1'b0;
        if (req_vec == 2'b10) begin
            winner = 1'b1;
        end
`ifdef SRAM_ARB_RR_EN
        // On contention the port that did not win last time goes first.
        else if (req_vec == 2'b11) begin
            winner = ~last_grant_reg;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (|req_vec) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (sram_ready) state_next = ACK;
            ACK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            op_wr_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
`ifdef SRAM_ARB_RR_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && |req_vec) begin
                grant_reg <= winner;
                // rd_en together with wr_en counts as a write
                op_wr_reg <= wr_vec[winner];
                addr_reg  <= winner ? req1_addr  : req0_addr;
                wdata_reg <= winner ? req1_wdata : req0_wdata;
`ifdef SRAM_ARB_RR_EN
                last_grant_reg <= winner;
`endif
            end
            if (state_reg == WAIT && sram_ready && !op_wr_reg) begin
                rdata_reg <= sram_rdata;
            end
        end
    end

    assign sram_rd_en = (state_reg == ISSUE || state_reg == WAIT) && !op_wr_reg;
    assign sram_wr_en = (state_reg == ISSUE || state_reg == WAIT) &&  op_wr_reg;
    assign sram_addr  = addr_reg;
    assign sram_wdata = wdata_reg;
    assign rdata      = rdata_reg;
    assign ack0       = ack_vec[0];
    assign ack1       = ack_vec[1];
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_rd_en, req0_wr_en, req1_rd_en, req1_wr_en;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        ack0, ack1, sram_rd_en, sram_wr_en, sram_ready, busy;
    logic [63:0] rdata, sram_rdata;
    logic [31:0] sram_addr, sram_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(32), .RDATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req0_rd_en(req0_rd_en), .req0_wr_en(req0_wr_en),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_rd_en(req1_rd_en), .req1_wr_en(req1_wr_en),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ready(sram_ready), .sram_rdata(sram_rdata),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is granted in an idle cycle, occupies the SRAM from
    // the following cycle, and acks the cycle after the first ready that
    // arrives strictly after the issue cycle.
    int          m_cyc = 0;
    bit          m_active = 1'b0;
    int          m_issue_cyc = -5;
    int          m_ack_cyc = -1;
    bit          m_port = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_last = 1'b1;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [63:0] m_rdata = '0;
    bit          r0, r1, pick;

    always_comb begin
        r0 = req0_rd_en | req0_wr_en;
        r1 = req1_rd_en | req1_wr_en;
        if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
            pick = (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
            pick = 1'b0;
`endif
        end else begin
            pick = r1 && !r0;
        end
    end

    always @(posedge clk) begin
        m_cyc <= m_cyc + 1;
        if (rst) begin
            m_active  <= 1'b0;
            m_ack_cyc <= -1;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_rdata   <= '0;
            m_last    <= 1'b1;
        end else if (!m_active) begin
            if (r0 || r1) begin
                m_active    <= 1'b1;
                m_issue_cyc <= m_cyc + 1;
                m_ack_cyc   <= -1;
                m_port      <= pick;
                m_last      <= pick;
                m_wr        <= pick ? req1_wr_en : req0_wr_en;
                m_addr      <= pick ? req1_addr  : req0_addr;
                m_wdata     <= pick ? req1_wdata : req0_wdata;
            end
        end else if (m_ack_cyc == m_cyc) begin
            m_active <= 1'b0;
        end else if (m_ack_cyc < 0 && m_cyc > m_issue_cyc && sram_ready) begin
            m_ack_cyc <= m_cyc + 1;
            if (!m_wr) m_rdata <= sram_rdata;
        end
    end

    bit chk_en = 1'b0;
    bit e_ack, e_en;

    always @(negedge clk) begin
        if (chk_en) begin
            e_ack = m_active && (m_cyc == m_ack_cyc);
            e_en  = m_active && !e_ack;
            chk("busy",       64'(busy),       64'(m_active));
            chk("sram_rd_en", 64'(sram_rd_en), 64'(e_en && !m_wr));
            chk("sram_wr_en", 64'(sram_wr_en), 64'(e_en && m_wr));
            chk("ack0",       64'(ack0),       64'(e_ack && !m_port));
            chk("ack1",       64'(ack1),       64'(e_ack && m_port));
            chk("sram_addr",  64'(sram_addr),  64'(m_addr));
            chk("sram_wdata", 64'(sram_wdata), 64'(m_wdata));
            chk("rdata",      rdata,           m_rdata);
        end
    end

    int rd_cnt = 0, wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    always @(negedge clk) begin
        if (sram_rd_en) rd_cnt   <= rd_cnt + 1;
        if (sram_wr_en) wr_cnt   <= wr_cnt + 1;
        if (ack0)       ack0_cnt <= ack0_cnt + 1;
        if (ack1)       ack1_cnt <= ack1_cnt + 1;
    end

    // Returns at the negedge of the issue cycle.
    task automatic wait_issue(input string name);
        int n = 0;
        @(negedge clk);
        while (!(sram_rd_en || sram_wr_en) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(sram_rd_en || sram_wr_en)) chk({name, "_issue_timeout"}, 64'd0, 64'd1);
    endtask

    // Ready arrives d cycles after issue; returns at the negedge of the ack cycle.
    task automatic complete_txn(input int d, input logic [63:0] data);
        repeat (d) @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = data;
        @(negedge clk);
        sram_ready = 1'b0;
    endtask

    int rd0, wr0, a00, a10;
    bit seq [4];
    bit exp_seq [4];

    initial begin
        rst = 1'b1;
        {req0_rd_en, req0_wr_en, req1_rd_en, req1_wr_en} = '0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        sram_ready = 1'b0; sram_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset then idle
        repeat (5) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_en",   64'({sram_rd_en, sram_wr_en, ack0, ack1}), 64'd0);
        chk("idle_addr", 64'(sram_addr), 64'd0);
        chk("idle_wdata", 64'(sram_wdata), 64'd0);
        chk("idle_rdata", rdata, 64'd0);
        $display("txn reset/idle done");

        // Port-0 read, ready 3 cycles after issue
        rd0 = rd_cnt; a00 = ack0_cnt; a10 = ack1_cnt;
        req0_rd_en = 1'b1; req0_addr = 32'h100;
        wait_issue("p0_read");
        chk("p0_read_addr", 64'(sram_addr), 64'h100);
        complete_txn(3, 64'h1122334455667788);
        chk("p0_read_ack0", 64'(ack0), 64'd1);
        chk("p0_read_ack1", 64'(ack1), 64'd0);
        chk("p0_read_rdata", rdata, 64'h1122334455667788);
        req0_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("p0_read_rd_cycles", 64'(rd_cnt - rd0), 64'd4);
        chk("p0_read_ack0_pulses", 64'(ack0_cnt - a00), 64'd1);
        chk("p0_read_ack1_pulses", 64'(ack1_cnt - a10), 64'd0);
        $display("txn p0 read addr 100 rdata %h", rdata);

        // Port-1 write
        wr0 = wr_cnt;
        req1_wr_en = 1'b1; req1_addr = 32'h40; req1_wdata = 32'hDEADBEEF;
        wait_issue("p1_write");
        chk("p1_write_wr_en", 64'(sram_wr_en), 64'd1);
        chk("p1_write_rd_en", 64'(sram_rd_en), 64'd0);
        complete_txn(2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("p1_write_ack1", 64'(ack1), 64'd1);
        chk("p1_write_ack0", 64'(ack0), 64'd0);
        chk("p1_write_addr", 64'(sram_addr), 64'h40);
        chk("p1_write_wdata", 64'(sram_wdata), 64'hDEADBEEF);
        chk("p1_write_rdata_kept", rdata, 64'h1122334455667788);
        req1_wr_en = 1'b0;
        @(negedge clk);
        chk("p1_write_wr_cycles", 64'(wr_cnt - wr0), 64'd3);
        $display("txn p1 write addr 40 data deadbeef");

        // Continuous contention, both reading
`ifdef SRAM_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        req0_rd_en = 1'b1; req0_addr = 32'h200;
        req1_rd_en = 1'b1; req1_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            wait_issue("contend");
            complete_txn(1, 64'h1000 + 64'(i));
            seq[i] = ack1;
            chk("contend_one_ack", 64'(ack0 ^ ack1), 64'd1);
            chk("contend_winner", 64'(seq[i]), 64'(exp_seq[i]));
            chk("contend_rdata", rdata, 64'h1000 + 64'(i));
            $display("txn contention %0d ack port %0d", i, seq[i]);
        end
        req0_rd_en = 1'b0; req1_rd_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during WAIT, then the held request completes
        a00 = ack0_cnt;
        req0_rd_en = 1'b1; req0_addr = 32'h500;
        wait_issue("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_en", 64'({sram_rd_en, sram_wr_en}), 64'd0);
        chk("rst_mid_ack", 64'({ack0, ack1}), 64'd0);
        chk("rst_mid_rdata", rdata, 64'd0);
        wait_issue("rst_retry");
        complete_txn(1, 64'hABCD_0000_1234_5678);
        chk("rst_retry_ack0", 64'(ack0), 64'd1);
        chk("rst_retry_rdata", rdata, 64'hABCD_0000_1234_5678);
        req0_rd_en = 1'b0;
        @(negedge clk);
        chk("rst_retry_ack_count", 64'(ack0_cnt - a00), 64'd1);
        $display("txn reset mid-wait then p0 read addr 500");

        // Port-1 address changes while waiting
        req1_rd_en = 1'b1; req1_addr = 32'h80;
        wait_issue("addr_hold");
        @(negedge clk);
        req1_addr = 32'hFFF0;
        complete_txn(2, 64'h5555);
        chk("addr_hold_ack1", 64'(ack1), 64'd1);
        chk("addr_hold_addr", 64'(sram_addr), 64'h80);
        req1_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        $display("txn p1 read addr 80 with addr change in wait");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
